// File: rtl/retire_monitor.sv
// retire_monitor: watches the writeback-stage PC stream of the core.
// It counts cycles and retired instructions and flags retirement of HALT_PC.
// A no-retire watchdog raises timeout if the pipeline hangs.
// Optional macro RETIRE_TRACE_EN adds an 8-entry history of retired PCs,
// read through trace_idx/trace_pc.
// The reset input is named rstn to match the core, but it is active-high and synchronous.
module retire_monitor #(
  parameter int                   ADDR_SIZE   = 32,
  parameter logic [ADDR_SIZE-1:0] HALT_PC     = ADDR_SIZE'(32'h00000078),
  parameter int                   WDOG_CYCLES = 64,
  parameter int                   CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_SIZE-1:0] pcW,
  input  logic                 validW,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [ADDR_SIZE-1:0] last_pc,
  output logic                 halt,
  output logic                 timeout,
  output logic                 done
`ifdef RETIRE_TRACE_EN
  ,
  input  logic [2:0]           trace_idx,
  output logic [ADDR_SIZE-1:0] trace_pc
`endif
);

  localparam int WD_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;

  state_t               state_reg, state_next;
  logic [WD_W-1:0]      wdog_reg;
  logic [CNT_W-1:0]     cycle_cnt_reg, retire_cnt_reg;
  logic [ADDR_SIZE-1:0] last_pc_reg;

  logic active, retire, retire_halt;

  // Only IDLE/RUN observe the core; the terminal states ignore inputs.
  assign active      = (state_reg == IDLE) || (state_reg == RUN);
  assign retire      = active && validW;
  assign retire_halt = retire && (pcW == HALT_PC);

  // Next-state logic. A halt retire wins over everything else.
  // Any retire clears the watchdog, so it can never overlap a timeout.
  always_comb begin
    state_next = state_reg;
    if (active) begin
      if (retire_halt)
        state_next = HALTED;
      else if (retire)
        state_next = RUN;
      else if (wdog_reg == WD_LAST)
        state_next = TIMEOUT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstn)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Watchdog: counts consecutive non-retiring cycles and holds once terminal.
  always_ff @(posedge clk) begin
    if (rstn)
      wdog_reg <= '0;
    else if (retire)
      wdog_reg <= '0;
    else if (active)
      wdog_reg <= wdog_reg + WD_W'(1);
  end

  // Saturating cycle and retire counters, plus the last retired PC.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cycle_cnt_reg  <= '0;
      retire_cnt_reg <= '0;
      last_pc_reg    <= '0;
    end else begin
      if (active && (cycle_cnt_reg != '1))
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      if (retire) begin
        if (retire_cnt_reg != '1)
          retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
        last_pc_reg <= pcW;
      end
    end
  end

  assign cycle_cnt  = cycle_cnt_reg;
  assign retire_cnt = retire_cnt_reg;
  assign last_pc    = last_pc_reg;
  assign halt       = (state_reg == HALTED);
  assign timeout    = (state_reg == TIMEOUT);
  assign done       = halt | timeout;

`ifdef RETIRE_TRACE_EN
  // The ring needs a reset clear, so it is built from plain registers rather than RAM.
  logic [2:0]           wr_ptr_reg;
  logic [ADDR_SIZE-1:0] trace_mem [8];
  logic [2:0]           rd_ptr;

  // Write pointer advances only when an instruction retires.
  always_ff @(posedge clk) begin
    if (rstn)
      wr_ptr_reg <= '0;
    else if (retire)
      wr_ptr_reg <= wr_ptr_reg + 3'd1;
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_trace
      // Each entry captures pcW when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (rstn)
          trace_mem[gi] <= '0;
        else if (retire && (wr_ptr_reg == 3'(gi)))
          trace_mem[gi] <= pcW;
      end
    end
  endgenerate

  // Index 0 is the newest entry, which sits one slot behind the write pointer.
  assign rd_ptr   = wr_ptr_reg - 3'd1 - trace_idx;
  assign trace_pc = trace_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// Self-checking bench for retire_monitor.
// It runs directed sequences and randomized retire/bubble streams,
// and compares every output each cycle against a history-based reference model.
module tb_retire_monitor;

  localparam logic [31:0] HALT = 32'h00000078;
  localparam int          WDOG = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] pcW = '0;
  logic        validW = 1'b0;
  logic [31:0] cycle_cnt, retire_cnt, last_pc;
  logic        halt, timeout, done;
`ifdef RETIRE_TRACE_EN
  logic [2:0]  trace_idx = '0;
  logic [31:0] trace_pc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the run is described by its retire history and idle streak.
  bit          m_halt, m_tmo;
  logic [31:0] m_cycle, m_ret, m_last;
  int          m_idle;
  logic [31:0] hist [$];

  retire_monitor #(
    .ADDR_SIZE(32), .HALT_PC(HALT), .WDOG_CYCLES(WDOG), .CNT_W(32)
  ) dut (
    .clk(clk), .rstn(rstn), .pcW(pcW), .validW(validW),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .last_pc(last_pc),
    .halt(halt), .timeout(timeout), .done(done)
`ifdef RETIRE_TRACE_EN
    , .trace_idx(trace_idx), .trace_pc(trace_pc)
`endif
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [31:0] pc);
    if (r) begin
      m_halt = 0; m_tmo = 0; m_cycle = '0; m_ret = '0; m_last = '0; m_idle = 0;
      hist.delete();
    end else if (!m_halt && !m_tmo) begin
      if (m_cycle != 32'hFFFF_FFFF) m_cycle++;
      if (v) begin
        if (m_ret != 32'hFFFF_FFFF) m_ret++;
        m_last = pc;
        hist.push_back(pc);
        if (hist.size() > 8) void'(hist.pop_front());
        m_idle = 0;
        if (pc == HALT) m_halt = 1;
      end else begin
        m_idle++;
        if (m_idle == WDOG) m_tmo = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("cycle_cnt", cycle_cnt, m_cycle);
    check("retire_cnt", retire_cnt, m_ret);
    check("last_pc", last_pc, m_last);
    check("halt", halt, m_halt);
    check("timeout", timeout, m_tmo);
    check("done", done, m_halt | m_tmo);
`ifdef RETIRE_TRACE_EN
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (i < hist.size()) ? hist[hist.size() - 1 - i] : 32'h0;
      trace_idx = 3'(i);
      #1;
      check("trace_pc", trace_pc, exp_pc);
    end
`endif
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, sample 1 ns later.
  task automatic step(input logic r, input logic v, input logic [31:0] pc);
    @(negedge clk);
    rstn = r; validW = v; pcW = pc;
    @(posedge clk);
    model_edge(r, v, pc);
    #1;
    compare_all();
  endtask

  initial begin
    int pct_tab [4] = '{0, 3, 50, 95};

    // Reset state
    step(1, 0, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_done", done, 0);

    // Straight-line program up to HALT_PC
    for (int i = 0; i <= 30; i++) step(0, 1, 32'(i * 4));
    check("tp1_halt", halt, 1);
    check("tp1_done", done, 1);
    check("tp1_retire", retire_cnt, 31);
    check("tp1_last", last_pc, 32'h78);
    check("tp1_cycle", cycle_cnt, 31);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h100);
    check("tp1_frozen", cycle_cnt, 31);

    // Reset out of HALTED, then identical run
    step(1, 1, 32'h78);
    check("tp5_rst_halt", halt, 0);
    check("tp5_rst_ret", retire_cnt, 0);
    for (int i = 0; i <= 30; i++) step(0, 1, 32'(i * 4));
    check("tp5_retire", retire_cnt, 31);
    check("tp5_cycle", cycle_cnt, 31);
    check("tp5_halt", halt, 1);

    // Watchdog expiry after exactly WDOG idle cycles
    step(1, 0, 0);
    step(0, 1, 32'h0);
    step(0, 1, 32'h4);
    for (int i = 0; i < WDOG - 1; i++) step(0, 0, 0);
    check("tp2_pre_tmo", timeout, 0);
    step(0, 0, 0);
    check("tp2_tmo", timeout, 1);
    check("tp2_halt", halt, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h78);
    check("tp2_sticky", timeout, 1);
    check("tp2_retire", retire_cnt, 2);

    // Bubbles interleaved with retires never time out
    step(1, 0, 0);
    step(0, 1, 32'h100);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'h104);
    for (int i = 0; i < WDOG - 1; i++) step(0, 0, 0);
    step(0, 1, 32'h108);
    check("tp3_no_tmo", timeout, 0);
    check("tp3_retire", retire_cnt, 3);

    // First retire is HALT_PC
    step(1, 0, 0);
    step(0, 1, HALT);
    check("tp4_halt", halt, 1);
    check("tp4_retire", retire_cnt, 1);
    check("tp4_cycle", cycle_cnt, 1);

    // Trace history
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 32'(32'h10 + i * 4));
`ifdef RETIRE_TRACE_EN
    trace_idx = 3'd0; #1;
    check("tp6_idx0", trace_pc, 32'h34);
    trace_idx = 3'd7; #1;
    check("tp6_idx7", trace_pc, 32'h18);
`endif

    // Randomized segments with varying retire density
    for (int seg = 0; seg < 30; seg++) begin
      int pct, n;
      pct = pct_tab[$urandom_range(0, 3)];
      n   = $urandom_range(50, 200);
      step(1, 0, 0);
      for (int k = 0; k < n; k++) begin
        logic        v, r;
        logic [31:0] pc;
        r  = ($urandom_range(0, 299) == 0);
        v  = ($urandom_range(0, 99) < pct);
        pc = ($urandom_range(0, 39) == 0) ? HALT : $urandom;
        step(r, v, pc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
